// File: rtl/audio_clock_regeneration_receiver.sv
// HDMI ACR packet receiver: validates N/CTS and regenerates the
// 128*fs and fs strobes in the pixel clock domain.

module audio_clock_regeneration_receiver #(
  parameter int LOCK_COUNT     = 2,
  parameter int CTS_TOLERANCE  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             packet_valid,
  input  logic [23:0]      header,
  input  logic [3:0][55:0] sub,
  output logic [19:0]      acr_n,
  output logic [19:0]      acr_cts,
  output logic             locked,
  output logic             clk_audio_x128_tick,
  output logic             sample_tick,
  output logic             packet_error
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [55:0] FIELD_MASK = 56'hFF_FF_0F_FF_FF_0F_00;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t        state_q;
  logic [19:0]   n_q;
  logic [19:0]   cts_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmr_q;
  logic [20:0]   acc_q;
  logic [6:0]    div_q;
  logic          locked_q;
  logic          tick_q;
  logic          stick_q;
  logic          err_q;

  logic [19:0] rx_n;
  logic [19:0] rx_cts;
  logic [19:0] dcts;
  logic        subs_eq;
  logic        is_acr;
  logic        good;
  logic        same_n;
  logic        match;
  logic        in_tol;
  logic        tmo;
  logic [20:0] sum;
  logic [20:0] acc_step;
  logic        wrap;
  logic        unused_hdr;

  assign unused_hdr = ^header[23:8];

  always_comb begin
    rx_n     = {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
    rx_cts   = {sub[0][11:8], sub[0][23:16], sub[0][31:24]};
    subs_eq  = (((sub[1] ^ sub[0]) & FIELD_MASK) == '0) &&
               (((sub[2] ^ sub[0]) & FIELD_MASK) == '0) &&
               (((sub[3] ^ sub[0]) & FIELD_MASK) == '0);
    is_acr   = packet_valid && (header[7:0] == 8'h01);
    good     = is_acr && subs_eq && (rx_n != '0) &&
               (rx_cts != '0) && (rx_n < rx_cts);
    same_n   = rx_n == n_q;
    match    = same_n && (rx_cts == cts_q);
    dcts     = (rx_cts >= cts_q) ? rx_cts - cts_q
                                 : cts_q - rx_cts;
    in_tol   = same_n &&
               ({1'b0, dcts} <= 21'(CTS_TOLERANCE));
    tmo      = tmr_q == TMO_LAST;
    sum      = acc_q + {1'b0, n_q};
    wrap     = sum >= {1'b0, cts_q};
    acc_step = wrap ? sum - {1'b0, cts_q} : sum;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q  <= UNLOCKED;
      n_q      <= '0;
      cts_q    <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      acc_q    <= '0;
      div_q    <= '0;
      locked_q <= 1'b0;
      tick_q   <= 1'b0;
      stick_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q   <= is_acr && !good;
      tick_q  <= 1'b0;
      stick_q <= 1'b0;
      unique case (state_q)
        UNLOCKED: begin
          tmr_q <= '0;
          acc_q <= '0;
          div_q <= '0;
          if (good) begin
            n_q   <= rx_n;
            cts_q <= rx_cts;
            cnt_q <= CW'(1);
            if (LOCK_COUNT <= 1) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              state_q <= ACQUIRE;
            end
          end
        end
        ACQUIRE: begin
          tmr_q <= tmr_q + 1'b1;
          if (good) begin
            tmr_q <= '0;
            if (!match) begin
              n_q   <= rx_n;
              cts_q <= rx_cts;
              cnt_q <= CW'(1);
            end else if (int'(cnt_q) + 1 >= LOCK_COUNT) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              acc_q    <= '0;
              div_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (tmo) begin
            state_q <= UNLOCKED;
            tmr_q   <= '0;
          end
        end
        LOCKED: begin
          tmr_q <= tmr_q + 1'b1;
          if (good && !in_tol) begin
            n_q      <= rx_n;
            cts_q    <= rx_cts;
            cnt_q    <= CW'(1);
            state_q  <= ACQUIRE;
            locked_q <= 1'b0;
            acc_q    <= '0;
            div_q    <= '0;
            tmr_q    <= '0;
          end else if (!good && tmo) begin
            state_q  <= UNLOCKED;
            locked_q <= 1'b0;
            acc_q    <= '0;
            div_q    <= '0;
            tmr_q    <= '0;
          end else begin
            acc_q <= acc_step;
            if (wrap) begin
              tick_q  <= 1'b1;
              div_q   <= div_q + 1'b1;
              stick_q <= div_q == 7'd127;
            end
            // in-tolerance CTS update keeps phase unless it overshoots
            if (good) begin
              cts_q <= rx_cts;
              tmr_q <= '0;
              if (acc_step >= {1'b0, rx_cts}) acc_q <= '0;
            end
          end
        end
        default: state_q <= UNLOCKED;
      endcase
    end
  end

  assign acr_n               = n_q;
  assign acr_cts             = cts_q;
  assign locked              = locked_q;
  assign clk_audio_x128_tick = tick_q;
  assign sample_tick         = stick_q;
  assign packet_error        = err_q;

endmodule

// File: tb/tb_audio_clock_regeneration_receiver.sv
// Bench for audio_clock_regeneration_receiver: directed sequences,
// a vector table and random traffic against a reference model.

module tb_audio_clock_regeneration_receiver;

  localparam int TO  = 1000;
  localparam int LC  = 2;
  localparam int TOL = 16;

  typedef logic [3:0][55:0] pkt_t;

  typedef struct {
    logic [7:0] hb0;
    int         n;
    int         c;
    int         bsub;
    int         bbit;
    bit         exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pv  = 1'b0;
  logic [23:0] hdr = '0;
  pkt_t        sb  = '0;
  logic [19:0] o_n;
  logic [19:0] o_cts;
  logic        o_lock;
  logic        o_tick;
  logic        o_stick;
  logic        o_err;

  audio_clock_regeneration_receiver #(
    .LOCK_COUNT    (LC),
    .CTS_TOLERANCE (TOL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_pixel          (clk),
    .reset              (rst),
    .packet_valid       (pv),
    .header             (hdr),
    .sub                (sb),
    .acr_n              (o_n),
    .acr_cts            (o_cts),
    .locked             (o_lock),
    .clk_audio_x128_tick(o_tick),
    .sample_tick        (o_stick),
    .packet_error       (o_err)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     trace_bad = 0;
  string  first_bad = "";
  int     cyc_no = 0;

  int     m_state = 0;
  int     m_n = 0;
  int     m_cts = 0;
  int     m_cnt = 0;
  int     m_div = 0;
  int     m_last = 0;
  longint m_acc = 0;
  bit     m_tick = 0;
  bit     m_stick = 0;
  bit     m_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_trace(input string nm);
    checks++;
    if (trace_bad != 0) begin
      errors++;
      $display("FAIL trace_%s: %0d cycles differ from model, required 0 (first: %s)",
               nm, trace_bad, first_bad);
    end
    trace_bad = 0;
  endtask

  function automatic logic [55:0] mk_sub(input int n, input int c);
    logic [55:0] s;
    s = {24'($urandom), $urandom};
    s[55:48] = n[7:0];
    s[47:40] = n[15:8];
    s[35:32] = n[19:16];
    s[31:24] = c[7:0];
    s[23:16] = c[15:8];
    s[11:8]  = c[19:16];
    return s;
  endfunction

  function automatic pkt_t mk_pkt(input int n, input int c);
    pkt_t p;
    for (int i = 0; i < 4; i++) p[i] = mk_sub(n, c);
    return p;
  endfunction

  task automatic accum();
    longint s;
    s = m_acc + m_n;
    if (s >= m_cts) begin
      m_acc  = s - m_cts;
      m_tick = 1;
      if (m_div == 127) m_stick = 1;
      m_div = (m_div + 1) % 128;
    end else begin
      m_acc = s;
    end
  endtask

  task automatic model_edge(input bit r, input bit v,
                            input logic [7:0] hb0, input pkt_t p);
    int fn[4];
    int fc[4];
    int d;
    bit acr;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      fn[i] = int'({p[i][35:32], p[i][47:40], p[i][55:48]});
      fc[i] = int'({p[i][11:8], p[i][23:16], p[i][31:24]});
    end
    acr = v && (hb0 == 8'h01);
    ok  = acr && fn[0] != 0 && fc[0] != 0 && fn[0] < fc[0];
    for (int i = 1; i < 4; i++)
      if (fn[i] != fn[0] || fc[i] != fc[0]) ok = 0;
    m_tick  = 0;
    m_stick = 0;
    if (r) begin
      m_state = 0; m_n = 0; m_cts = 0; m_cnt = 0;
      m_acc = 0; m_div = 0; m_err = 0; m_last = cyc_no;
    end else begin
      m_err = acr && !ok;
      d = fc[0] - m_cts;
      if (d < 0) d = -d;
      case (m_state)
        0: if (ok) begin
          m_n = fn[0]; m_cts = fc[0]; m_cnt = 1;
          m_state = (LC <= 1) ? 2 : 1;
          m_acc = 0; m_div = 0; m_last = cyc_no;
        end
        1: if (ok) begin
          m_last = cyc_no;
          if (fn[0] == m_n && fc[0] == m_cts) begin
            m_cnt++;
            if (m_cnt >= LC) begin
              m_state = 2; m_acc = 0; m_div = 0;
            end
          end else begin
            m_n = fn[0]; m_cts = fc[0]; m_cnt = 1;
          end
        end else if (cyc_no - m_last == TO) begin
          m_state = 0; m_last = cyc_no;
        end
        default: begin
          if (ok && fn[0] == m_n && d <= TOL) begin
            accum();
            m_cts = fc[0];
            if (m_acc >= m_cts) m_acc = 0;
            m_last = cyc_no;
          end else if (ok) begin
            m_n = fn[0]; m_cts = fc[0]; m_cnt = 1;
            m_state = 1; m_acc = 0; m_div = 0; m_last = cyc_no;
          end else if (cyc_no - m_last == TO) begin
            m_state = 0; m_acc = 0; m_div = 0; m_last = cyc_no;
          end else begin
            accum();
          end
        end
      endcase
    end
  endtask

  task automatic drive(input bit r, input bit v,
                       input logic [7:0] hb0, input pkt_t p);
    rst = r;
    pv  = v;
    hdr = {16'($urandom), hb0};
    sb  = p;
    @(posedge clk);
    cyc_no++;
    model_edge(r, v, hb0, p);
    #1;
    if (o_n !== 20'(m_n) || o_cts !== 20'(m_cts) ||
        o_lock !== (m_state == 2) || o_tick !== m_tick ||
        o_stick !== m_stick || o_err !== m_err) begin
      if (trace_bad == 0)
        first_bad = $sformatf(
          "cyc %0d n %0d/%0d cts %0d/%0d lk %b/%b tk %b/%b st %b/%b er %b/%b",
          cyc_no, o_n, m_n, o_cts, m_cts, o_lock, m_state == 2,
          o_tick, m_tick, o_stick, m_stick, o_err, m_err);
      trace_bad++;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(0, 0, 8'h00, '0);
  endtask

  task automatic send(input int n, input int c);
    drive(0, 1, 8'h01, mk_pkt(n, c));
  endtask

  task automatic send_raw(input logic [7:0] hb0, input pkt_t p);
    drive(0, 1, hb0, p);
  endtask

  task automatic run_count(input int cycles, input int n, input int c,
                           output int tk, output int st,
                           output int mn, output int mx);
    int last;
    tk = 0; st = 0; mn = 1 << 30; mx = 0; last = -1;
    for (int i = 0; i < cycles; i++) begin
      if (i % 900 == 899) send(n, c);
      else idle(1);
      if (o_tick === 1'b1) tk++;
      if (o_stick === 1'b1) begin
        st++;
        if (last >= 0) begin
          if (cyc_no - last < mn) mn = cyc_no - last;
          if (cyc_no - last > mx) mx = cyc_no - last;
        end
        last = cyc_no;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    pkt_t p;
    int   tk, st, mn, mx, k, bn, bc, r, kind, jc, si, bi;

    tbl[0] = '{8'h01, 6144, 25300, 2, 24, 1'b1};
    tbl[1] = '{8'h01, 0, 25300, -1, 0, 1'b1};
    tbl[2] = '{8'h01, 30000, 25200, -1, 0, 1'b1};
    tbl[3] = '{8'h01, 6144, 0, -1, 0, 1'b1};
    tbl[4] = '{8'h01, 6144, 25300, 1, 33, 1'b1};
    tbl[5] = '{8'h02, 1000, 2000, -1, 0, 1'b0};
    tbl[6] = '{8'h02, 0, 0, -1, 0, 1'b0};
    tbl[7] = '{8'h01, 6144, 25300, 3, 38, 1'b0};

    drive(1, 0, 8'h00, '0);
    drive(1, 1, 8'h01, mk_pkt(6144, 25200));
    chk("rst_n", o_n, 0);
    chk("rst_cts", o_cts, 0);
    chk("rst_locked", o_lock, 0);
    chk("rst_ticks", {o_tick, o_stick}, 0);
    chk("rst_err", o_err, 0);

    send(6144, 25200);
    chk("acq_n", o_n, 6144);
    chk("acq_cts", o_cts, 25200);
    chk("acq_locked", o_lock, 0);
    idle(99);
    send(6144, 25200);
    chk("lock_2nd", o_lock, 1);
    run_count(25200, 6144, 25200, tk, st, mn, mx);
    chk("x128_48k", tk, 6144);
    chk("fs_48k", st, 48);
    chk("fs_gap_min", mn, 525);
    chk("fs_gap_max", mx, 525);
    check_trace("lock48k");

    send(6144, 25210);
    chk("tol_cts", o_cts, 25210);
    chk("tol_locked", o_lock, 1);
    send(6144, 25300);
    chk("out_tol_locked", o_lock, 0);
    chk("out_tol_cts", o_cts, 25300);
    send(6144, 25300);
    chk("relock", o_lock, 1);
    check_trace("tolerance");

    for (int i = 0; i < 8; i++) begin
      p = mk_pkt(tbl[i].n, tbl[i].c);
      if (tbl[i].bsub >= 0)
        p[tbl[i].bsub][tbl[i].bbit] = ~p[tbl[i].bsub][tbl[i].bbit];
      send_raw(tbl[i].hb0, p);
      chk($sformatf("vec%0d_err", i), o_err, tbl[i].exp_err);
      chk($sformatf("vec%0d_locked", i), o_lock, 1);
      chk($sformatf("vec%0d_n", i), o_n, 6144);
      chk($sformatf("vec%0d_cts", i), o_cts, 25300);
      idle(1);
      chk($sformatf("vec%0d_err_pulse", i), o_err, 0);
    end
    check_trace("table");

    send(6144, 25300);
    idle(TO - 1);
    chk("to_before", o_lock, 1);
    idle(1);
    chk("to_expire", o_lock, 0);
    chk("to_keep_cts", o_cts, 25300);
    send(6144, 25300);
    send(6144, 25300);
    chk("to_relock", o_lock, 1);
    idle(TO - 1);
    send(6144, 25300);
    chk("to_pkt_wins", o_lock, 1);
    idle(1);
    chk("to_pkt_wins_next", o_lock, 1);
    check_trace("timeout");

    drive(1, 0, 8'h00, '0);
    send(6144, 25200);
    send(6144, 25200);
    tk = 0;
    k = 0;
    while (tk < 64 && k < 2000) begin
      idle(1);
      k++;
      if (o_tick === 1'b1) tk++;
    end
    chk("div64_reached", tk, 64);
    drive(1, 0, 8'h00, '0);
    chk("mid_rst_locked", o_lock, 0);
    chk("mid_rst_n", o_n, 0);
    chk("mid_rst_cts", o_cts, 0);
    chk("mid_rst_ticks", {o_tick, o_stick, o_err}, 0);
    tk = 0;
    for (int i = 0; i < 1500; i++) begin
      idle(1);
      if (o_tick === 1'b1) tk++;
    end
    send(6144, 25200);
    chk("post_rst_one_pkt", o_lock, 0);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (o_tick === 1'b1) tk++;
    end
    chk("post_rst_no_ticks", tk, 0);
    send(6144, 25200);
    chk("post_rst_relock", o_lock, 1);
    check_trace("reset");

    drive(1, 0, 8'h00, '0);
    send(6272, 28000);
    send(6272, 28000);
    chk("lock_44k", o_lock, 1);
    run_count(28000, 6272, 28000, tk, st, mn, mx);
    chk("x128_44k", tk, 6272);
    chk("fs_44k", st, 49);
    check_trace("lock44k");

    bn = 6;
    bc = 11;
    for (int i = 0; i < 6000; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        drive(1, 0, 8'h00, '0);
      end else if (r < 25) begin
        kind = $urandom_range(0, 5);
        case (kind)
          0, 1: send(bn, bc);
          2: begin
            jc = bc + $urandom_range(0, 40) - 20;
            if (jc < 0) jc = 0;
            send(bn, jc);
          end
          3: begin
            bn = $urandom_range(1, 60);
            bc = bn + $urandom_range(1, 80);
            send(bn, bc);
          end
          4: begin
            p  = mk_pkt(bn, bc);
            si = $urandom_range(1, 3);
            bi = 48 + $urandom_range(0, 7);
            p[si][bi] = ~p[si][bi];
            send_raw(8'h01, p);
          end
          default: send_raw(8'($urandom_range(2, 255)), mk_pkt(bn, bc));
        endcase
      end else begin
        idle(1);
      end
    end
    check_trace("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_clock_regeneration_receiver.md
# audio_clock_regeneration_receiver

Sink-side counterpart of the HDMI audio clock regeneration (ACR) packet generator. It consumes decoded data-island packets, validates ACR packets (type 0x01), and extracts N and CTS. It then regenerates the audio timing in the `clk_pixel` domain with a fractional-N accumulator, which outputs a 128·fs strobe and an fs sample strobe. It sits after the packet decoder and feeds the audio sample FIFO / I2S output stage.

## Interface
Parameters:
- `LOCK_COUNT`, 2: consecutive matching valid ACR packets needed to enter LOCKED.
- `CTS_TOLERANCE`, 16: maximum |ΔCTS| accepted in LOCKED without losing lock.
- `TIMEOUT_CYCLES`, 1_000_000: cycles with no valid ACR packet before lock is dropped.

Ports:
- `clk_pixel`  in  1  sole clock. One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high.
- `packet_valid`  in  1  one-cycle strobe; `header` and `sub` are valid this cycle.
- `header`  in  24  packet header; HB0 = `header[7:0]`.
- `sub`  in  56 ×4 (`sub[3:0]`)  subpackets.
- `acr_n`  out  20  current N.
- `acr_cts`  out  20  current CTS.
- `locked`  out  1  regeneration running.
- `clk_audio_x128_tick`  out  1  one-cycle pulse at 128·fs.
- `sample_tick`  out  1  one-cycle pulse at fs.
- `packet_error`  out  1  one-cycle pulse on a rejected ACR packet.

## Operation
- **Subpacket field layout** (all four subpackets identical):
  - `[55:48]` N[7:0], `[47:40]` N[15:8], `[35:32]` N[19:16].
  - `[31:24]` CTS[7:0], `[23:16]` CTS[15:8], `[11:8]` CTS[19:16].
  - Bits `[39:36]`, `[15:12]` and `[7:0]` are ignored.
- **Packet classification:**
  - A packet with HB0 ≠ 0x01 is ignored entirely: no error, no timer reset. HB1 and HB2 are ignored.
  - An ACR packet is **valid** when all of the following hold: `sub[0..3]` are equal on non-ignored bits, N ≠ 0, CTS ≠ 0, and N < CTS.
  - Any other ACR packet pulses `packet_error` and is otherwise discarded.
- **States:** UNLOCKED (reset), ACQUIRE, LOCKED.
- **UNLOCKED:**
  - On a valid packet: latch N/CTS, set match count = 1, go to ACQUIRE.
  - If `LOCK_COUNT` = 1, go directly to LOCKED instead.
- **ACQUIRE:**
  - A valid packet with identical N and CTS increments the match count. When it reaches `LOCK_COUNT`: go to LOCKED, acc = 0, div = 0.
  - A valid packet that differs relatches N/CTS and sets count = 1.
  - Timeout → UNLOCKED.
- **LOCKED:**
  - A valid packet with the same N and |CTS − `acr_cts`| ≤ `CTS_TOLERANCE` updates `acr_cts`.
    - If acc ≥ the new CTS, acc is cleared in the same update.
  - A valid packet with a different N, or CTS outside tolerance: relatch, count = 1, go to ACQUIRE, `locked` = 0.
  - Timeout → UNLOCKED.
- **Timeout counter:** cleared on each valid ACR packet and on every state change; counts otherwise. It fires when the count reaches `TIMEOUT_CYCLES` − 1. If a valid packet arrives in the same cycle, the packet wins and no timeout occurs.
- **Accumulator (LOCKED only):**
  - Width is 21 bits, because acc + N < 2·CTS ≤ 2^21.
  - Each cycle: s = acc + N. If s ≥ CTS: acc = s − CTS and `clk_audio_x128_tick` = 1. Otherwise acc = s.
  - The resulting tick rate is f_pix·N/CTS = 128·fs.
- **Divider:** a 7-bit counter `div` increments on each x128 tick. `sample_tick` pulses on the tick where `div` wraps from 127 to 0.
- **Outside LOCKED:** acc, div and both tick outputs are held at 0.

## Timing
- Reset values: all outputs are 0, state = UNLOCKED, acc = div = timeout = match count = 0.
- Reset has priority over every other event, including mid-packet and mid-lock. Outputs are 0 on the cycle after reset is sampled high.
- Latency of `packet_valid` at cycle t:
  - `acr_n`, `acr_cts`, the state and `packet_error` update at t+1.
  - `locked` rises at t+1 on the locking packet.
  - The first accumulator add happens at t+1, so the first x128 tick can occur at t+1 at the earliest.
- `acr_n` and `acr_cts` show the latched values in every state. They are 0 only after reset.
- Both ticks are registered, single-cycle and never back-to-back for `sample_tick`. `clk_audio_x128_tick` can be asserted on consecutive cycles only if 2N ≥ CTS.
- When `packet_valid` is asserted on consecutive cycles, each packet is processed independently, in order.

## Test plan
- Reset, then two valid packets 100 cycles apart with N = 6144, CTS = 25200 → `locked` = 1 one cycle after the 2nd packet. Over the next 25200 cycles: exactly 6144 x128 ticks and 48 `sample_tick` pulses, with `sample_tick` spacing of 525 cycles.
- In LOCKED, a packet with CTS = 25210 → `acr_cts` = 25210, `locked` stays 1, no tick discontinuity. A packet with CTS = 25300 → `locked` = 0 next cycle and the state is ACQUIRE. One further matching packet relocks.
- Malformed packets: `sub[2]` differs, N = 0, N = 30000 with CTS = 25200, or CTS = 0 → `packet_error` pulse each time, state unchanged. A packet with HB0 = 0x02 → no error and no state effect.
- Timeout with `TIMEOUT_CYCLES` = 1000: lock, then send no packets → `locked` drops at exactly 1000 cycles after the last valid packet. A valid packet arriving in the expiry cycle keeps lock.
- Assert `reset` while LOCKED with `div` = 64 → next cycle all outputs are 0 and the state is UNLOCKED. After release, no ticks occur until `LOCK_COUNT` new valid packets arrive.
- N = 6272, CTS = 28000 (44.1 kHz at 25.2 MHz) → over 28000 cycles: 6272 x128 ticks and 49 `sample_tick` pulses. The accumulator never reaches or exceeds CTS after an update.
